// File: rtl/sl_leaf_mem.sv
// ============================================================================
//  Module      : sl_leaf_mem (with package sl_pkg)
//  Description : Same-latency (SL) interconnect leaf responder. Terminates one
//                SL request/response link with a single word-addressed memory
//                bank. Writes land one edge after sampling; reads return
//                after a fixed RD_LAT edges with full throughput.
//                Optional feature macro: SL_LEAF_ADDRCHK_EN (bank-id check on
//                upper address bits plus saturating err_cnt output port).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sl_pkg;
    localparam int SL_ADDR_W = 16;
    localparam int SL_DATA_W = 32;

    typedef struct packed {
        logic                 wen;
        logic [SL_ADDR_W-1:0] waddr;
        logic [SL_DATA_W-1:0] wdata;
    } sl_wreq_t;

    typedef struct packed {
        logic                 ren;
        logic [SL_ADDR_W-1:0] raddr;
    } sl_rreq_t;

    typedef struct packed {
        sl_wreq_t wreq;
        sl_rreq_t rreq;
    } sl_req_t;

    typedef struct packed {
        logic                 rvalid;
        logic [SL_DATA_W-1:0] rdata;
    } sl_res_t;
endpackage

module sl_leaf_mem
    import sl_pkg::*;
#(
    parameter int ADDR_W  = SL_ADDR_W,
    parameter int DATA_W  = SL_DATA_W,
    parameter int DEPTH   = 1024,
    parameter int RD_LAT  = 2,
    parameter int BANK_ID = 0
) (
    input  logic    clk,
    input  logic    rst,
    input  sl_req_t req,
    output sl_res_t res
`ifdef SL_LEAF_ADDRCHK_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    // Latency outside 1..8 would break the tree-wide same-latency contract.
    generate
        if (RD_LAT < 1 || RD_LAT > 8) begin : g_bad_rd_lat
            $error("sl_leaf_mem: RD_LAT must be within 1..8");
        end
    endgenerate

    logic [IDX_W-1:0] w_widx;
    logic [IDX_W-1:0] w_ridx;
    logic             w_wr_ok;
    logic             w_rd_ok;

    assign w_widx = req.wreq.waddr[IDX_W-1:0];
    assign w_ridx = req.rreq.raddr[IDX_W-1:0];

`ifdef SL_LEAF_ADDRCHK_EN
    localparam logic [ADDR_W-IDX_W-1:0] c_bank = (ADDR_W-IDX_W)'(BANK_ID);

    logic [1:0]  w_err_inc;
    logic [15:0] r_err_cnt;

    assign w_wr_ok   = (req.wreq.waddr[ADDR_W-1:IDX_W] == c_bank);
    assign w_rd_ok   = (req.rreq.raddr[ADDR_W-1:IDX_W] == c_bank);
    assign w_err_inc = {1'b0, req.wreq.wen & ~w_wr_ok} + {1'b0, req.rreq.ren & ~w_rd_ok};

    // Saturating count of requests that targeted a different bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (r_err_cnt > (16'hFFFF - {14'd0, w_err_inc})) begin
            r_err_cnt <= 16'hFFFF;
        end else begin
            r_err_cnt <= r_err_cnt + {14'd0, w_err_inc};
        end
    end

    assign err_cnt = r_err_cnt;
`else
    // Upper address bits alias into the bank when no check is built in.
    logic w_unused_bank_bits;

    assign w_wr_ok            = 1'b1;
    assign w_rd_ok            = 1'b1;
    assign w_unused_bank_bits = ^{req.wreq.waddr[ADDR_W-1:IDX_W],
                                  req.rreq.raddr[ADDR_W-1:IDX_W],
                                  (BANK_ID != 0)};
`endif

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [RD_LAT-1:0] r_vld;
    logic [DATA_W-1:0] r_dat [RD_LAT];

    // Array write; contents survive reset, only the write strobe is gated.
    always_ff @(posedge clk) begin
        if (!rst && req.wreq.wen && w_wr_ok) begin
            r_mem[w_widx] <= req.wreq.wdata;
        end
    end

    // Stage 0 is the array read register (old word on same-index write);
    // later stages are a plain shift. Idle slots carry all-zero so parent
    // cells can OR-merge responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= req.rreq.ren;
            if (!req.rreq.ren) begin
                r_dat[0] <= '0;
            end else if (w_rd_ok) begin
                r_dat[0] <= r_mem[w_ridx];
            end else begin
                r_dat[0] <= '1;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    assign res.rvalid = r_vld[RD_LAT-1];
    assign res.rdata  = r_dat[RD_LAT-1];

endmodule

`default_nettype wire

// File: tb/tb_sl_leaf_mem.sv
// ============================================================================
//  Module      : tb_sl_leaf_mem
//  Description : Self-checking bench for sl_leaf_mem: fixed vector table,
//                hand sequences, and randomized traffic against a scheduled
//                response model. Honors SL_LEAF_ADDRCHK_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sl_leaf_mem;
    import sl_pkg::*;

    localparam int RD_LAT  = 2;
    localparam int DEPTH   = 1024;
    localparam int BANK_ID = 3;

    logic    clk = 1'b0;
    logic    rst;
    sl_req_t req;
    sl_res_t res;
`ifdef SL_LEAF_ADDRCHK_EN
    logic [15:0] err_cnt;
`endif

    always #5 clk = ~clk;

    sl_leaf_mem #(
        .ADDR_W (16),
        .DATA_W (32),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT),
        .BANK_ID(BANK_ID)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .res    (res)
`ifdef SL_LEAF_ADDRCHK_EN
        ,
        .err_cnt(err_cnt)
`endif
    );

    // Reference model: bank contents, responses keyed by the cycle in which
    // they must be visible, and the error count.
    logic [31:0] mdl_mem [DEPTH];
    logic [32:0] sched [int];
    int          mdl_err;
    int          cyc;
    int          n_vec;
    int          n_bad;

    typedef struct {
        bit          r;
        bit          we;
        logic [15:0] wa;
        logic [31:0] wd;
        bit          re;
        logic [15:0] ra;
        bit          ev;
        logic [31:0] ed;
    } vec_t;

    vec_t tab [18];

    function automatic logic [15:0] mk(input int idx);
        mk = {6'(BANK_ID), 10'(idx)};
    endfunction

    function automatic bit bank_ok(input logic [15:0] a);
`ifdef SL_LEAF_ADDRCHK_EN
        bank_ok = (a[15:10] == 6'(BANK_ID));
`else
        bank_ok = (a[15:10] == a[15:10]) || 1'b1;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    // One cycle: apply inputs, advance the model, check outputs mid-cycle.
    task automatic drive(input bit r, input bit we, input logic [15:0] wa,
                         input logic [31:0] wd, input bit re, input logic [15:0] ra,
                         output logic gv, output logic [31:0] gd);
        logic [32:0] e;
        int          cur_err;
        int          keys [$];
        int          inc;
        rst             = r;
        req.wreq.wen    = we;
        req.wreq.waddr  = wa;
        req.wreq.wdata  = wd;
        req.rreq.ren    = re;
        req.rreq.raddr  = ra;
        e = 33'd0;
        if (sched.exists(cyc)) begin
            e = sched[cyc];
            sched.delete(cyc);
        end
        cur_err = mdl_err;
        if (r) begin
            foreach (sched[k]) keys.push_back(k);
            foreach (keys[i]) sched.delete(keys[i]);
            mdl_err = 0;
        end else begin
            inc = 0;
            if (re) begin
                if (bank_ok(ra)) sched[cyc+RD_LAT] = {1'b1, mdl_mem[ra[9:0]]};
                else begin
                    sched[cyc+RD_LAT] = {1'b1, 32'hFFFF_FFFF};
                    inc++;
                end
            end
            if (we) begin
                if (bank_ok(wa)) mdl_mem[wa[9:0]] = wd;
                else inc++;
            end
            mdl_err = (mdl_err + inc > 65535) ? 65535 : mdl_err + inc;
        end
        @(negedge clk);
        gv = res.rvalid;
        gd = res.rdata;
        chk("model_res", {31'd0, gv, gd}, {31'd0, e});
`ifdef SL_LEAF_ADDRCHK_EN
        chk("model_err_cnt", {48'd0, err_cnt}, 64'(cur_err));
`endif
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(output logic gv, output logic [31:0] gd);
        drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0, gv, gd);
    endtask

    initial begin
        logic        gv;
        logic [31:0] gd;
        n_vec   = 0;
        n_bad   = 0;
        cyc     = 0;
        mdl_err = 0;
        rst     = 1'b1;
        req     = '0;
        @(posedge clk);
        #1;

        // Reset held, then idle: everything must stay zero.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0, gv, gd);
        for (int i = 0; i < 4; i++) begin
            idle(gv, gd);
            chk("reset_idle", {31'd0, gv, gd}, 64'd0);
        end

        // Vector table: expected output is the value visible in that cycle.
        tab[0]  = '{0, 1, mk(10'h005), 32'hDEAD_BEEF, 0, 16'h0, 0, 32'h0};
        tab[1]  = '{0, 0, 16'h0, 32'h0, 1, mk(10'h005), 0, 32'h0};
        tab[2]  = '{0, 0, 16'h0, 32'h0, 0, 16'h0, 0, 32'h0};
        tab[3]  = '{0, 0, 16'h0, 32'h0, 0, 16'h0, 1, 32'hDEAD_BEEF};
        tab[4]  = '{0, 0, 16'h0, 32'h0, 0, 16'h0, 0, 32'h0};
        tab[5]  = '{0, 1, mk(10'h020), 32'h1, 0, 16'h0, 0, 32'h0};
        tab[6]  = '{0, 1, mk(10'h020), 32'h2, 1, mk(10'h020), 0, 32'h0};
        tab[7]  = '{0, 0, 16'h0, 32'h0, 1, mk(10'h020), 0, 32'h0};
        tab[8]  = '{0, 0, 16'h0, 32'h0, 0, 16'h0, 1, 32'h1};
        tab[9]  = '{0, 0, 16'h0, 32'h0, 0, 16'h0, 1, 32'h2};
        tab[10] = '{0, 0, 16'h0, 32'h0, 0, 16'h0, 0, 32'h0};
        tab[11] = '{0, 0, 16'h0, 32'h0, 1, mk(10'h005), 0, 32'h0};
        tab[12] = '{1, 1, mk(10'h005), 32'h0BAD_0BAD, 1, mk(10'h020), 0, 32'h0};
        tab[13] = '{0, 0, 16'h0, 32'h0, 0, 16'h0, 0, 32'h0};
        tab[14] = '{0, 0, 16'h0, 32'h0, 0, 16'h0, 0, 32'h0};
        tab[15] = '{0, 0, 16'h0, 32'h0, 1, mk(10'h005), 0, 32'h0};
        tab[16] = '{0, 0, 16'h0, 32'h0, 0, 16'h0, 0, 32'h0};
        tab[17] = '{0, 0, 16'h0, 32'h0, 0, 16'h0, 1, 32'hDEAD_BEEF};
        for (int i = 0; i < 18; i++) begin
            drive(tab[i].r, tab[i].we, tab[i].wa, tab[i].wd, tab[i].re, tab[i].ra, gv, gd);
            chk($sformatf("table_%0d", i), {31'd0, gv, gd}, {31'd0, tab[i].ev, tab[i].ed});
        end

        // Preload mem[i] = i*0x11, then 8 back-to-back reads.
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, mk(i), 32'(i * 32'h11), 1'b0, 16'h0, gv, gd);
        for (int j = 0; j < 8 + RD_LAT; j++) begin
            drive(1'b0, 1'b0, 16'h0, 32'h0, (j < 8), mk(j), gv, gd);
            if (j >= RD_LAT) chk("burst", {31'd0, gv, gd}, {31'd0, 1'b1, 32'((j - RD_LAT) * 32'h11)});
            else             chk("burst_lead", {31'd0, gv, gd}, 64'd0);
        end

`ifdef SL_LEAF_ADDRCHK_EN
        // Bank check: fresh count after a reset, then in-bank / out-of-bank.
        drive(1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0, gv, gd);
        drive(1'b0, 1'b1, 16'h0C10, 32'h0000_1234, 1'b0, 16'h0, gv, gd);
        drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 16'h0C10, gv, gd);
        drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 16'h0410, gv, gd);
        drive(1'b0, 1'b1, 16'h0410, 32'h5555_5555, 1'b0, 16'h0, gv, gd);
        chk("chk_read_ok", {31'd0, gv, gd}, {31'd0, 1'b1, 32'h0000_1234});
        drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 16'h0C10, gv, gd);
        chk("chk_read_bad", {31'd0, gv, gd}, {31'd0, 1'b1, 32'hFFFF_FFFF});
        chk("chk_err_cnt", {48'd0, err_cnt}, 64'd2);
        idle(gv, gd);
        idle(gv, gd);
        chk("chk_write_dropped", {31'd0, gv, gd}, {31'd0, 1'b1, 32'h0000_1234});
`else
        // Aliasing: upper address bits are ignored.
        drive(1'b0, 1'b1, 16'h0410, 32'hA5A5_0001, 1'b0, 16'h0, gv, gd);
        drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 16'hF810, gv, gd);
        idle(gv, gd);
        idle(gv, gd);
        chk("alias", {31'd0, gv, gd}, {31'd0, 1'b1, 32'hA5A5_0001});
`endif

        // Randomized traffic over a preloaded window of indices 0x40..0x7F.
        for (int i = 0; i < 64; i++) drive(1'b0, 1'b1, mk(64 + i), $urandom, 1'b0, 16'h0, gv, gd);
        for (int i = 0; i < 400; i++) begin
            logic [5:0]  hw;
            logic [5:0]  hr;
`ifdef SL_LEAF_ADDRCHK_EN
            hw = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'(BANK_ID);
            hr = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'(BANK_ID);
`else
            hw = 6'($urandom);
            hr = 6'($urandom);
`endif
            drive(($urandom_range(0, 39) == 0), 1'($urandom), {hw, 10'(64 + $urandom_range(0, 63))},
                  $urandom, 1'($urandom), {hr, 10'(64 + $urandom_range(0, 63))}, gv, gd);
        end
        for (int i = 0; i < RD_LAT + 1; i++) idle(gv, gd);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sl_leaf_mem.md
Name: sl_leaf_mem

Overview:
- Leaf responder of the same-latency (SL) interconnect tree; terminates one SL_REQ/SL_RES link at the bottom of a chain of 2:1 routing cells.
- Holds one word-addressed memory bank.
- Performs writes and returns read data with a fixed, compile-time latency, so every leaf in the tree answers in an identical number of cycles.
- No backpressure exists; each accepted read yields exactly one response.

Parameters:
- ADDR_W, 16, width of waddr/raddr in SL_REQ (must match package).
- DATA_W, 32, width of wdata/rdata (must match package).
- DEPTH, 1024, words in the bank; power of two; local index = addr[$clog2(DEPTH)-1:0].
- RD_LAT, 2, cycles from ren sampled to rvalid asserted; legal range 1..8.
- BANK_ID, 0, value expected on addr[ADDR_W-1:$clog2(DEPTH)]; used only with the optional feature.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- req  input  SL_REQ  request from parent cell; fields wreq.wen/waddr/wdata and rreq.ren/raddr
- res  output  SL_RES  response to parent cell; fields rvalid/rdata
- err_cnt  output  16  address-mismatch count; present only with SL_LEAF_ADDRCHK_EN

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values:
  - res.rvalid = 0 and res.rdata = 0 on the first edge with rst = 1.
  - All RD_LAT pipeline stages are cleared, so in-flight reads are discarded and produce no response.
  - err_cnt = 0.
  - Memory contents are not cleared and persist across reset.
- Requests are accepted every cycle rst = 0. No ready signal exists; the parent guarantees at most one wen and one ren per cycle.
- Write:
  - When req.wreq.wen = 1 at edge t, mem[waddr idx] <= wdata, visible to reads sampled at edge t+1 onward.
- Read:
  - When req.rreq.ren = 1 at edge t, res.rvalid = 1 and res.rdata = mem[raddr idx] are presented during the cycle after edge t+RD_LAT-1, i.e. registered output RD_LAT edges after sampling.
  - Stage 1 is the array read register. Stages 2..RD_LAT form a shift pipeline carrying {valid, data}.
- Back-to-back reads: full throughput, one response per cycle, order preserved.
- When no read is in a slot, that slot outputs rvalid = 0 and rdata = 0. The all-zero idle value is required by the OR/priority merge in parent cells.
- Same-cycle wen and ren to the same index: read-before-write. The read returns the old word; the new word lands after the edge.
- Same-cycle wen and ren to different indices: both serviced independently.
- Address wrap: bits above the index are ignored (aliasing) unless the optional feature is enabled.
- Reset asserted mid-stream: outputs are zero on the cycle following the reset edge. Reads accepted on the edge where rst = 1 are ignored. Writes are also ignored while rst = 1.
- Pipeline is a plain shift with no stall path; occupancy never exceeds RD_LAT.

Optional Feature:
- Macro: SL_LEAF_ADDRCHK_EN.
- Defined:
  - Each wen/ren checks addr[ADDR_W-1:$clog2(DEPTH)] == BANK_ID.
  - On mismatch, a write is dropped (no array update).
  - On mismatch, a read still returns exactly one response at RD_LAT with rvalid = 1 and rdata = {DATA_W{1'b1}}, so the same-latency contract holds.
  - err_cnt increments by 1 per mismatching request, by 2 if wen and ren both mismatch in one cycle. It saturates at 16'hFFFF. The err_cnt port exists.
- Undefined: no check is made, addresses alias into the bank, and the err_cnt port is absent.

Test Plan:
- Reset then idle, RD_LAT = 2 → res.rvalid = 0 and res.rdata = 0 on every cycle.
- Write 0xDEADBEEF to addr 0x005 at cycle 10; read 0x005 at cycle 11 → rvalid = 1 and rdata = 0xDEADBEEF at cycle 13; rvalid = 0 at cycles 12 and 14.
- Reads to addrs 0..7 on 8 consecutive cycles after preload mem[i] = i*0x11 → 8 consecutive responses 0x00, 0x11, …, 0x77 in order, starting RD_LAT cycles after the first read.
- mem[0x20] = 0x1, then same-cycle wen (0x20, 0x2) and ren 0x20 → response 0x1; a read of 0x20 one cycle later returns 0x2.
- Issue 2 reads, assert rst for 1 cycle before they complete → no rvalid pulse for either read; mem[0x005] still reads 0xDEADBEEF after reset.
- With SL_LEAF_ADDRCHK_EN, DEPTH = 1024, BANK_ID = 3: read 0x0C10 → normal data; read 0x0410 → rdata = 0xFFFFFFFF and err_cnt = 1; write 0x0410 → array unchanged and err_cnt = 2.
